// File: rtl/game_flow_controller.sv
// game_flow_controller: maze game sequencer covering the menu, the map preview and ROM-checked player moves.
// Define GAME_FLOW_MOVE_COUNT_EN to add the saturating move_count output.
module game_flow_controller #(
   parameter int          MAP_W     = 30,
   parameter int          MAP_H     = 21,
   parameter int          ADDRW     = 5,
   parameter int          START_X   = 0,
   parameter int          START_Y   = 20,
   parameter int          GOAL_X    = 29,
   parameter int          GOAL_Y    = 0,
   parameter logic [31:0] SHOW_EASY = 32'd300000000,
   parameter logic [31:0] SHOW_MED  = 32'd200000000,
   parameter logic [31:0] SHOW_HARD = 32'd100000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_sel,
   output logic             rom_req,
   output logic [ADDRW-1:0] rom_addr,
   input  logic [MAP_W-1:0] rom_data,
   output logic [3:0]       game_state,
   output logic [2:0]       menu_sel,
   output logic [2:0]       difficulty,
   output logic             in_instr,
   output logic             map_visible,
   output logic [7:0]       player_x,
   output logic [7:0]       player_y
`ifdef GAME_FLOW_MOVE_COUNT_EN
   ,
   output logic [15:0]      move_count
`endif
);

   localparam int XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;

   localparam logic [2:0] MS_START = 3'b001;
   localparam logic [2:0] MS_DIFF  = 3'b010;
   localparam logic [2:0] MS_INSTR = 3'b100;
   localparam logic [2:0] D_EASY   = 3'b001;
   localparam logic [2:0] D_MED    = 3'b010;
   localparam logic [2:0] D_HARD   = 3'b100;

   typedef enum logic [2:0] {
      S_MENU, S_INSTR, S_SHOW, S_PLAY, S_ISSUE, S_CHECK, S_LOST, S_WON
   } state_t;

   state_t      state;
   logic [31:0] timer;
   logic [7:0]  cand_x;
   logic [7:0]  cand_y;
   logic [31:0] show_load;

   logic act_sel, act_up, act_down, act_left, act_right, any_btn, move_req;
   logic signed [8:0] cur_x, cur_y, step_x, step_y, next_x, next_y;
   logic in_map, wall_hit, at_goal;

   // Only the highest-priority pulse acts; the rest are dropped this cycle.
   assign act_sel   = btn_sel;
   assign act_up    = !btn_sel && btn_up;
   assign act_down  = !btn_sel && !btn_up && btn_down;
   assign act_left  = !btn_sel && !btn_up && !btn_down && btn_left;
   assign act_right = !btn_sel && !btn_up && !btn_down && !btn_left && btn_right;
   assign any_btn   = btn_sel | btn_up | btn_down | btn_left | btn_right;
   assign move_req  = act_up | act_down | act_left | act_right;

   // Signed 9-bit candidate so stepping left of x=0 shows up as negative.
   assign cur_x  = $signed({1'b0, player_x});
   assign cur_y  = $signed({1'b0, player_y});
   assign next_x = cur_x + step_x;
   assign next_y = cur_y + step_y;
   assign in_map = !next_x[8] && (next_x[7:0] < 8'(MAP_W)) &&
                   !next_y[8] && (next_y[7:0] < 8'(MAP_H));

   assign wall_hit = rom_data[cand_x[XW-1:0]];
   assign at_goal  = (cand_x == 8'(GOAL_X)) && (cand_y == 8'(GOAL_Y));

   always_comb begin
      step_x = 9'sd0;
      step_y = 9'sd0;
      if (act_up)         step_y = -9'sd1;
      else if (act_down)  step_y = 9'sd1;
      else if (act_left)  step_x = -9'sd1;
      else if (act_right) step_x = 9'sd1;
   end

   always_comb begin
      case (difficulty)
         D_MED:   show_load = SHOW_MED;
         D_HARD:  show_load = SHOW_HARD;
         default: show_load = SHOW_EASY;
      endcase
   end

   always_comb begin
      case (state)
         S_MENU, S_INSTR:                  game_state = 4'b0001;
         S_SHOW, S_PLAY, S_ISSUE, S_CHECK: game_state = 4'b0010;
         S_LOST:                           game_state = 4'b0100;
         default:                          game_state = 4'b1000;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_MENU;
         menu_sel    <= MS_START;
         difficulty  <= D_EASY;
         player_x    <= 8'(START_X);
         player_y    <= 8'(START_Y);
         map_visible <= 1'b0;
         rom_req     <= 1'b0;
         rom_addr    <= '0;
         in_instr    <= 1'b0;
         timer       <= 32'd0;
         cand_x      <= 8'd0;
         cand_y      <= 8'd0;
`ifdef GAME_FLOW_MOVE_COUNT_EN
         move_count  <= 16'd0;
`endif
      end else begin
         case (state)
            S_MENU: begin
               if (act_sel) begin
                  if (menu_sel == MS_START) begin
                     state       <= S_SHOW;
                     timer       <= show_load;
                     player_x    <= 8'(START_X);
                     player_y    <= 8'(START_Y);
                     map_visible <= 1'b1;
`ifdef GAME_FLOW_MOVE_COUNT_EN
                     move_count  <= 16'd0;
`endif
                  end else if (menu_sel == MS_INSTR) begin
                     state    <= S_INSTR;
                     in_instr <= 1'b1;
                  end
               end else if (act_up) begin
                  if (menu_sel == MS_DIFF) difficulty <= {difficulty[0], difficulty[2:1]};
               end else if (act_down) begin
                  if (menu_sel == MS_DIFF) difficulty <= {difficulty[1:0], difficulty[2]};
               end else if (act_left) begin
                  if (menu_sel == MS_START)      menu_sel <= MS_DIFF;
                  else if (menu_sel == MS_INSTR) menu_sel <= MS_START;
               end else if (act_right) begin
                  if (menu_sel == MS_DIFF)       menu_sel <= MS_START;
                  else if (menu_sel == MS_START) menu_sel <= MS_INSTR;
               end
            end
            S_INSTR: begin
               if (any_btn) begin
                  state    <= S_MENU;
                  in_instr <= 1'b0;
                  menu_sel <= MS_START;
               end
            end
            S_SHOW: begin
               if (timer <= 32'd1) begin
                  state       <= S_PLAY;
                  map_visible <= 1'b0;
                  timer       <= 32'd0;
               end else begin
                  timer <= timer - 32'd1;
               end
            end
            S_PLAY: begin
               if (move_req && in_map) begin
                  cand_x   <= next_x[7:0];
                  cand_y   <= next_y[7:0];
                  rom_addr <= next_y[ADDRW-1:0];
                  rom_req  <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_CHECK;
            end
            // Row data for cand_y is valid now; the move commits whatever the outcome.
            S_CHECK: begin
               rom_req  <= 1'b0;
               player_x <= cand_x;
               player_y <= cand_y;
`ifdef GAME_FLOW_MOVE_COUNT_EN
               if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
`endif
               if (wall_hit) begin
                  state       <= S_LOST;
                  map_visible <= 1'b1;
               end else if (at_goal) begin
                  state       <= S_WON;
                  map_visible <= 1'b1;
               end else begin
                  state <= S_PLAY;
               end
            end
            S_LOST, S_WON: begin
               if (act_sel) begin
                  state       <= S_MENU;
                  menu_sel    <= MS_START;
                  player_x    <= 8'(START_X);
                  player_y    <= 8'(START_Y);
                  map_visible <= 1'b0;
               end
            end
            default: state <= S_MENU;
         endcase
      end
   end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Central sequencer for the maze game. It owns the one-hot game state, menu and difficulty selection, the map-preview timer, and player position.
- Performs collision and goal checks by issuing reads to the synchronous map ROM (one row of MAP_W bits per address, 1-cycle read latency).
- Sits between the debounced button pulses and the VGA renderer. The renderer consumes state, map_visible and position; the top level muxes rom_addr to the controller whenever rom_req=1.

Parameters:
- MAP_W, 30, bits per map row (x range 0..MAP_W-1)
- MAP_H, 21, map rows (y range 0..MAP_H-1)
- ADDRW, 5, ROM address width, ceil(log2(MAP_H))
- START_X, 0, player reset x
- START_Y, 20, player reset y
- GOAL_X, 29, goal x
- GOAL_Y, 0, goal y
- SHOW_EASY, 300000000, map-preview cycles, easy
- SHOW_MED, 200000000, map-preview cycles, medium
- SHOW_HARD, 100000000, map-preview cycles, hard

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_up/btn_down/btn_left/btn_right  in  1 each  single-cycle debounced pulses (SCEN)
- btn_sel  in  1  single-cycle select pulse
- rom_req  out  1  controller owns ROM port this cycle
- rom_addr  out  ADDRW  ROM row address
- rom_data  in  MAP_W  row data, valid 1 cycle after address; bit x = wall
- game_state  out  4  one-hot: MENU=0001, GAME=0010, LOST=0100, WON=1000
- menu_sel  out  3  START=001, DIFF=010, INSTR=100
- difficulty  out  3  EASY=001, MED=010, HARD=100
- in_instr  out  1  instructions screen active
- map_visible  out  1  renderer draws walls
- player_x, player_y  out  8 each  player cell

Behaviour:
- Reset (reset=0, async) state:
  - Internal state MENU; menu_sel=START; difficulty=EASY.
  - player_x=START_X, player_y=START_Y.
  - map_visible=0, rom_req=0, rom_addr=0, in_instr=0, timer=0.
- Internal states: MENU, INSTR, SHOW, PLAY, ISSUE, CHECK, LOST, WON. game_state maps these as follows:
  - MENU and INSTR -> 0001
  - SHOW, PLAY, ISSUE and CHECK -> 0010
  - LOST -> 0100
  - WON -> 1000
- Button priority: only one button acts per cycle, in the order sel > up > down > left > right. Lower-priority pulses in the same cycle are dropped.
- MENU:
  - left: START->DIFF, INSTR->START, DIFF holds.
  - right: DIFF->START, START->INSTR, INSTR holds.
  - If menu_sel=DIFF: up rotates difficulty EASY->HARD->MED->EASY; down rotates EASY->MED->HARD->EASY.
  - sel with menu_sel=START -> SHOW. Load timer with the SHOW_* value for the current difficulty; set player to start; map_visible=1.
  - sel with menu_sel=INSTR -> INSTR, in_instr=1.
  - sel with menu_sel=DIFF: no effect.
- INSTR: any button pulse -> MENU, in_instr=0, menu_sel=START.
- SHOW:
  - Timer decrements each cycle. When timer=1, next state is PLAY and map_visible=0, so preview length is exactly SHOW_* cycles.
  - Buttons are ignored.
- PLAY: a direction pulse computes the candidate cell.
  - If the candidate is off-map (x<0, x>MAP_W-1, y<0, y>MAP_H-1), the move is rejected: state stays PLAY, no ROM access.
  - Otherwise latch the candidate, drive rom_addr=cand_y with rom_req=1, and go to ISSUE.
- ISSUE: rom_req=1, hold address; go to CHECK.
- CHECK: rom_data is valid; rom_req=0.
  - rom_data[cand_x]=1: commit position -> LOST.
  - Else if cand==(GOAL_X,GOAL_Y): commit -> WON.
  - Else commit -> PLAY.
  - Check latency is 3 cycles from pulse to position update. Pulses arriving in ISSUE/CHECK are dropped.
- LOST/WON: map_visible=1. sel -> MENU with menu_sel=START and player reset to start; other buttons are ignored.
- Width rules: candidate arithmetic is 9-bit signed internally, so x=0 minus 1 is detected as off-map rather than wrapping to 255.
- Timer is 32-bit unsigned.
- Reset asserted mid-check: immediately returns to reset values; the pending check is discarded.

Optional Feature:
- Macro: GAME_FLOW_MOVE_COUNT_EN.
- With the macro defined:
  - Adds output move_count (16-bit).
  - Increments on every committed move (CHECK commit), saturating at 16'hFFFF.
  - Cleared on reset and on MENU->SHOW.
- Without the macro: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then pulse right, right, sel, up, sel -> menu_sel INSTR after right 1, holds INSTR after right 2, in_instr=1 after sel, back to MENU with menu_sel=START after up.
- Left, then up, then left: first left -> menu_sel=DIFF; up -> difficulty=HARD; second left holds DIFF. Then right, then sel with SHOW_HARD=100 -> map_visible=1 for exactly 100 cycles, then state PLAY with map_visible=0.
- In PLAY at (0,20): pulse left -> no rom_req, position unchanged. Pulse down -> no rom_req (y=20 is the last row).
- In PLAY at (0,20): pulse up with rom_data row 19 = 0 -> rom_req high 2 cycles, rom_addr=19, player_y=19 on the 3rd cycle, state stays PLAY.
- Pulse right with rom_data bit1=1 -> player_x=1, game_state=0100. Then sel -> 0001 with player at (0,20).
- Reach (28,0), pulse right with bit29=0 -> game_state=1000. Assert reset during ISSUE of a later move -> all outputs return to reset values asynchronously.
